// File: rtl/efuse_rd_ctrl_if.sv
// APB slave bundle for the eFuse read sequencer.
// The master modport is the fabric side; the slave modport is efuse_rd_ctrl.
interface efuse_rd_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/efuse_rd_ctrl.sv
// APB-programmable eFuse read sequencer: takes a word address and START,
// runs the csb/strobe timing on the macro and captures the returned word.
module efuse_rd_ctrl #(
    parameter int EFUSE_BIT      = 1024,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int APB_DATA_WIDTH = 8,
    parameter int SETUP_CYC      = 2,
    parameter int STRB_CYC       = 4,
    localparam int NWORD         = EFUSE_BIT / APB_DATA_WIDTH,
    localparam int EADDR_W       = $clog2(NWORD)
) (
    input  logic                      clk,
    input  logic                      rstn,
    efuse_rd_ctrl_if.slave            apb,
    output logic                      efuse_csb,
    output logic                      efuse_strobe,
    output logic [EADDR_W-1:0]        efuse_addr,
    input  logic [APB_DATA_WIDTH-1:0] efuse_dout,
    output logic                      irq
);

    localparam int CNT_MAX = (SETUP_CYC > STRB_CYC) ? SETUP_CYC : STRB_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STRB_LOAD  = CNT_W'(STRB_CYC - 1);

    localparam logic [APB_ADDR_WIDTH-1:0] REG_CTRL   = APB_ADDR_WIDTH'(0);
    localparam logic [APB_ADDR_WIDTH-1:0] REG_ADDR   = APB_ADDR_WIDTH'(1);
    localparam logic [APB_ADDR_WIDTH-1:0] REG_STATUS = APB_ADDR_WIDTH'(2);
    localparam logic [APB_ADDR_WIDTH-1:0] REG_RDATA  = APB_ADDR_WIDTH'(3);

    localparam logic [APB_DATA_WIDTH:0] NWORD_LIM = (APB_DATA_WIDTH + 1)'(NWORD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_CAPT
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [APB_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [EADDR_W-1:0]        eaddr_q, eaddr_d;
    logic                      csb_q, csb_d;
    logic                      strobe_q, strobe_d;

    logic access;
    logic wr_access;
    logic sel_ctrl;
    logic sel_addr;
    logic sel_status;
    logic sel_rdata;
    logic sel_bad;
    logic busy;
    logic addr_ok;
    logic start_req;
    logic start_go;
    logic start_oor;
    logic addr_wr_ok;

    assign access     = apb.psel & apb.penable;
    assign wr_access  = access & apb.pwrite;
    assign sel_ctrl   = (apb.paddr == REG_CTRL);
    assign sel_addr   = (apb.paddr == REG_ADDR);
    assign sel_status = (apb.paddr == REG_STATUS);
    assign sel_rdata  = (apb.paddr == REG_RDATA);
    assign sel_bad    = ~(sel_ctrl | sel_addr | sel_status | sel_rdata);

    assign busy       = (state_q != ST_IDLE);
    assign addr_ok    = ({1'b0, addr_q} < NWORD_LIM);
    assign start_req  = wr_access & sel_ctrl & apb.pwdata[0];
    assign start_go   = start_req & ~busy & addr_ok;
    assign start_oor  = start_req & ~busy & ~addr_ok;
    assign addr_wr_ok = wr_access & sel_addr & ~busy;

    // Rejected accesses: unmapped address, START while busy or out of range,
    // and ADDR writes that would disturb an in-flight read.
    assign apb.pslverr = access & (sel_bad
                                   | (start_req & (busy | ~addr_ok))
                                   | (wr_access & sel_addr & busy));
    assign apb.pready  = 1'b1;

    always_comb begin
        apb.prdata = '0;
        case (apb.paddr)
            REG_ADDR:   apb.prdata = addr_q;
            REG_STATUS: apb.prdata = {{(APB_DATA_WIDTH-3){1'b0}}, err_q, done_q, busy};
            REG_RDATA:  apb.prdata = rdata_q;
            default:    apb.prdata = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        rdata_d  = rdata_q;
        done_d   = done_q;
        err_d    = err_q;
        eaddr_d  = eaddr_q;

        if (addr_wr_ok) begin
            addr_d = apb.pwdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    eaddr_d = addr_q[EADDR_W-1:0];
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = STRB_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_d = ST_IDLE;
                rdata_d = efuse_dout;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear first so a hardware set in the same cycle takes priority.
        if (wr_access & sel_status & apb.pwdata[1]) begin
            done_d = 1'b0;
        end
        if (wr_access & sel_status & apb.pwdata[2]) begin
            err_d = 1'b0;
        end
        if (state_q == ST_CAPT) begin
            done_d = 1'b1;
        end
        if (start_oor) begin
            err_d = 1'b1;
        end

        csb_d    = (state_d == ST_IDLE);
        strobe_d = (state_d == ST_STROBE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            eaddr_q  <= '0;
            csb_q    <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            eaddr_q  <= eaddr_d;
            csb_q    <= csb_d;
            strobe_q <= strobe_d;
        end
    end

    assign efuse_csb    = csb_q;
    assign efuse_strobe = strobe_q;
    assign efuse_addr   = eaddr_q;
    assign irq          = done_q;

endmodule

// File: tb/tb_efuse_rd_ctrl.sv
// Directed-plus-random bench for efuse_rd_ctrl with a fuse-array model
// and a register-level reference model of the sequencer.
module tb_efuse_rd_ctrl;

    localparam int SETUP = 2;
    localparam int STRB  = 4;
    localparam int NWORD = 128;
    localparam int LAT   = SETUP + STRB + 2;
    localparam int WIN   = LAT + 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       efuse_csb;
    logic       efuse_strobe;
    logic [6:0] efuse_addr;
    logic [7:0] efuse_dout;
    logic       irq;

    logic [7:0] mem [NWORD];
    logic       strobe_d1;
    logic       strobe_prev = 1'b0;
    int         pulse_cnt = 0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_addr;
    logic [7:0] m_rdata;
    logic       m_done;
    logic       m_err;
    logic [6:0] m_eaddr;

    always #5 clk = ~clk;

    efuse_rd_ctrl_if #(.ADDR_W(8), .DATA_W(8)) apb_if ();

    efuse_rd_ctrl #(
        .EFUSE_BIT      (1024),
        .APB_ADDR_WIDTH (8),
        .APB_DATA_WIDTH (8),
        .SETUP_CYC      (SETUP),
        .STRB_CYC       (STRB)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .apb          (apb_if),
        .efuse_csb    (efuse_csb),
        .efuse_strobe (efuse_strobe),
        .efuse_addr   (efuse_addr),
        .efuse_dout   (efuse_dout),
        .irq          (irq)
    );

    // Fuse macro: data is only valid while strobe is high and one cycle after.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) strobe_d1 <= 1'b0;
        else       strobe_d1 <= efuse_strobe;
    end
    assign efuse_dout = (efuse_strobe || strobe_d1) ? mem[efuse_addr] : ~mem[efuse_addr];

    always @(negedge clk) begin
        if (efuse_strobe && !strobe_prev) pulse_cnt <= pulse_cnt + 1;
        strobe_prev <= efuse_strobe;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] a, input logic [7:0] d,
                                 output logic [7:0] rd, output logic err);
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = wr;
        apb_if.paddr   = a;
        apb_if.pwdata  = d;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        #1;
        rd  = apb_if.prdata;
        err = apb_if.pslverr;
        @(posedge clk); #1;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
    endtask

    task automatic regWrite(input string tag, input logic [7:0] a, input logic [7:0] d, input logic exp_err);
        logic [7:0] rd;
        logic       err;
        applyStimulus(1'b1, a, d, rd, err);
        checkOutput(tag, 32'(err), 32'(exp_err));
    endtask

    task automatic checkRead(input string tag, input logic [7:0] a, input logic [7:0] exp, input logic exp_err);
        logic [7:0] rd;
        logic       err;
        applyStimulus(1'b0, a, 8'h00, rd, err);
        checkOutput(tag, {23'b0, err, rd}, {23'b0, exp_err, exp});
    endtask

    function automatic logic [31:0] span(input int lo, input int hi);
        logic [31:0] s = '0;
        for (int k = lo; k <= hi; k++) s[k] = 1'b1;
        return s;
    endfunction

    // Bit k of each mask is the sample taken k cycles after the START edge.
    task automatic watchSeq(input int n, input logic [6:0] exp_ea,
                            output logic [31:0] csb_low, output logic [31:0] strb,
                            output logic [31:0] irqm, output int ea_bad);
        csb_low = '0;
        strb    = '0;
        irqm    = '0;
        ea_bad  = 0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            csb_low[k] = ~efuse_csb;
            strb[k]    = efuse_strobe;
            irqm[k]    = irq;
            if (efuse_addr !== exp_ea) ea_bad++;
        end
    endtask

    task automatic waitIrq(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("irq_wait", 32'(irq), 1);
    endtask

    task automatic doRead(input logic [7:0] a, input logic clr);
        logic [31:0] cm, sm, im;
        int          eb;
        logic        oor;
        logic        prev_done;
        logic [6:0]  exp_ea;
        regWrite("addr_wr", 8'h01, a, 1'b0);
        m_addr    = a;
        oor       = ({24'b0, a} >= 32'(NWORD));
        prev_done = m_done;
        exp_ea    = oor ? m_eaddr : a[6:0];
        regWrite("start", 8'h00, 8'h01, oor);
        watchSeq(WIN, exp_ea, cm, sm, im, eb);
        if (oor) begin
            checkOutput("csb_idle", cm, 0);
            checkOutput("strobe_idle", sm, 0);
            checkOutput("irq_seq", im, prev_done ? span(1, WIN) : 32'h0);
            m_err = 1'b1;
        end else begin
            checkOutput("csb_window", cm, span(1, LAT - 1));
            checkOutput("strobe_window", sm, span(SETUP + 1, SETUP + STRB));
            checkOutput("irq_seq", im, prev_done ? span(1, WIN) : span(LAT, WIN));
            m_done  = 1'b1;
            m_rdata = mem[a[6:0]];
            m_eaddr = a[6:0];
        end
        checkOutput("eaddr_stable", 32'(eb), 0);
        checkRead("status", 8'h02, {5'b0, m_err, m_done, 1'b0}, 1'b0);
        checkRead("rdata", 8'h03, m_rdata, 1'b0);
        checkRead("addr_rb", 8'h01, m_addr, 1'b0);
        if (clr) begin
            regWrite("w1c", 8'h02, 8'h06, 1'b0);
            m_done = 1'b0;
            m_err  = 1'b0;
            checkOutput("irq_clr", 32'(irq), 0);
            checkRead("status_clr", 8'h02, 8'h00, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        int         p0;

        rstn           = 1'b0;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = 8'h00;
        apb_if.pwdata  = 8'h00;
        for (int i = 0; i < NWORD; i++) mem[i] = 8'($urandom);
        mem[5]  = 8'hA5;
        m_addr  = 8'h00;
        m_rdata = 8'h00;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_eaddr = 7'd0;

        repeat (3) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;

        // Reset state
        checkOutput("rst_csb", 32'(efuse_csb), 1);
        checkOutput("rst_strobe", 32'(efuse_strobe), 0);
        checkOutput("rst_irq", 32'(irq), 0);
        checkOutput("rst_eaddr", 32'(efuse_addr), 0);
        checkOutput("rst_pready", 32'(apb_if.pready), 1);
        checkRead("rst_ctrl", 8'h00, 8'h00, 1'b0);
        checkRead("rst_addr", 8'h01, 8'h00, 1'b0);
        checkRead("rst_status", 8'h02, 8'h00, 1'b0);
        checkRead("rst_rdata", 8'h03, 8'h00, 1'b0);

        // Known word 5 -> 0xA5, then W1C done
        doRead(8'h05, 1'b1);

        // Random reads, some out of range, done/err sometimes left set
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 4) == 0) a = 8'($urandom_range(128, 255));
            else                           a = 8'($urandom_range(0, 127));
            doRead(a, 1'($urandom_range(0, 1)));
        end
        regWrite("w1c_all", 8'h02, 8'h06, 1'b0);
        m_done = 1'b0;
        m_err  = 1'b0;

        // START and ADDR write while busy are rejected
        a = 8'($urandom_range(0, 127));
        b = a ^ 8'h01;
        regWrite("coll_addr", 8'h01, a, 1'b0);
        m_addr = a;
        p0 = pulse_cnt;
        regWrite("coll_start", 8'h00, 8'h01, 1'b0);
        regWrite("start_busy", 8'h00, 8'h01, 1'b1);
        regWrite("addr_busy", 8'h01, b, 1'b1);
        waitIrq(20);
        @(posedge clk); #1;
        checkOutput("one_pulse", 32'(pulse_cnt - p0), 1);
        m_done  = 1'b1;
        m_rdata = mem[a[6:0]];
        m_eaddr = a[6:0];
        checkRead("coll_rdata", 8'h03, m_rdata, 1'b0);
        checkRead("coll_addr_rb", 8'h01, m_addr, 1'b0);
        checkRead("coll_status", 8'h02, 8'h02, 1'b0);

        // Out of range START, then W1C of err alone
        doRead(8'h80, 1'b0);
        regWrite("w1c_err", 8'h02, 8'h04, 1'b0);
        m_err = 1'b0;
        checkRead("err_clr", 8'h02, {5'b0, m_err, m_done, 1'b0}, 1'b0);
        regWrite("w1c_done", 8'h02, 8'h02, 1'b0);
        m_done = 1'b0;

        // Async reset in the middle of the strobe
        a = 8'($urandom_range(0, 127));
        regWrite("rst_addr_wr", 8'h01, a, 1'b0);
        regWrite("rst_start", 8'h00, 8'h01, 1'b0);
        repeat (SETUP + 1) begin
            @(posedge clk); #1;
        end
        checkOutput("pre_rst_strobe", 32'(efuse_strobe), 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("rst_mid_csb", 32'(efuse_csb), 1);
        checkOutput("rst_mid_strobe", 32'(efuse_strobe), 0);
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        m_addr  = 8'h00;
        m_rdata = 8'h00;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_eaddr = 7'd0;
        checkRead("post_rst_rdata", 8'h03, 8'h00, 1'b0);
        checkRead("post_rst_status", 8'h02, 8'h00, 1'b0);
        checkRead("post_rst_addr", 8'h01, 8'h00, 1'b0);
        checkOutput("post_rst_eaddr", 32'(efuse_addr), 0);
        doRead(8'($urandom_range(0, 127)), 1'b1);

        // W1C of done landing in the capture cycle: the set wins
        a = 8'($urandom_range(0, 127));
        regWrite("capt_addr", 8'h01, a, 1'b0);
        m_addr = a;
        regWrite("capt_start", 8'h00, 8'h01, 1'b0);
        repeat (SETUP + STRB - 1) begin
            @(posedge clk); #1;
        end
        regWrite("w1c_capt", 8'h02, 8'h02, 1'b0);
        m_done  = 1'b1;
        m_rdata = mem[a[6:0]];
        m_eaddr = a[6:0];
        checkOutput("capt_irq", 32'(irq), 1);
        checkRead("capt_status", 8'h02, 8'h02, 1'b0);
        checkRead("capt_rdata", 8'h03, m_rdata, 1'b0);

        // Back-to-back: second START in the first idle cycle
        a = 8'($urandom_range(0, 127));
        regWrite("b2b_addr", 8'h01, a, 1'b0);
        m_addr = a;
        p0 = pulse_cnt;
        regWrite("b2b_start1", 8'h00, 8'h01, 1'b0);
        repeat (SETUP + STRB) begin
            @(posedge clk); #1;
        end
        regWrite("b2b_start2", 8'h00, 8'h01, 1'b0);
        checkOutput("b2b_csb", 32'(efuse_csb), 0);
        mem[a[6:0]] = ~mem[a[6:0]];
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
        checkOutput("b2b_pulses", 32'(pulse_cnt - p0), 2);
        checkOutput("b2b_csb_end", 32'(efuse_csb), 1);
        m_rdata = mem[a[6:0]];
        checkRead("b2b_rdata", 8'h03, m_rdata, 1'b0);

        // Unmapped address and write-only CTRL
        checkRead("bad_rd", 8'h07, 8'h00, 1'b1);
        regWrite("bad_wr", 8'h07, 8'hFF, 1'b1);
        checkRead("bad_status", 8'h02, {5'b0, m_err, m_done, 1'b0}, 1'b0);
        checkRead("ctrl_rd", 8'h00, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
